bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/serial_pkg.sv | 15 +
 rtl/byte_fifo.sv | 80 ++++++++
 rtl/bit_serializer.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the byte-to-bit serializer and its byte FIFO.
//   BYTE_W        : width of one queued byte
//   DEFAULT_DEPTH : default number of byte FIFO entries
//   ser_state_e   : serializer FSM state encoding
package serial_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO feeding the serializer. Pointers wrap naturally because DEPTH is a
// power of two; the level counter is the only full/empty indicator.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the FIFO on this edge (pushes/pops ignored)
//   push       : write push_data (ignored when full)
//   push_data  : byte to write
//   pop        : advance the read pointer (ignored when empty)
//   pop_data   : current head entry
//   level      : number of queued entries
module byte_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] pop_data,
    output logic [LW-1:0]     level
);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              push_ok, pop_ok;

    assign push_ok = push && (level_q != FULL_LEVEL);
    assign pop_ok  = pop && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read while the level says valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/bit_serializer.sv
// Byte-to-bit serializer: bytes are queued in a byte_fifo and shifted out one
// bit per accepted handshake, back-to-back with no idle bubble between bytes.
//
//   state | meaning
//   IDLE  | nothing in flight, bit_valid=0, bit_out=0
//   SHIFT | byte in shift register, bit_cnt bits remain after the current one
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   byte_valid/byte_data   : upstream byte offer
//   byte_ready             : FIFO not full (registered-state based)
//   flush                  : drop queued and in-flight data
//   bit_valid/bit_out      : serial output
//   bit_ready              : downstream accepts the current bit
//   busy                   : byte in flight or FIFO non-empty
//   fifo_level             : queued bytes
//   bytes_sent             : fully transmitted bytes (wrapping)
module bit_serializer
    import serial_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid,
    input  logic [BYTE_W-1:0]      byte_data,
    output logic                   byte_ready,
    input  logic                   flush,
    output logic                   bit_valid,
    output logic                   bit_out,
    input  logic                   bit_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            bytes_sent
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    ser_state_e        state_q;
    logic [BYTE_W-1:0] sr_q;
    logic [2:0]        bit_cnt_q;
    logic [15:0]       sent_q;

    logic [LW-1:0]     level;
    logic [BYTE_W-1:0] head;
    logic              fifo_ne;
    logic              push, pop, xfer, last_xfer;
    logic [BYTE_W-1:0] sr_shift_d;

    assign fifo_ne    = (level != '0);
    assign byte_ready = (level != FULL_LEVEL);
    assign push       = byte_valid && byte_ready && !flush;
    assign xfer       = (state_q == SHIFT) && bit_ready;
    assign last_xfer  = xfer && (bit_cnt_q == 3'd0);
    // Head is consumed either to start from idle or to chain onto a finished byte.
    assign pop        = !flush && fifo_ne && ((state_q == IDLE) || last_xfer);
    assign sr_shift_d = MSB_FIRST ? {sr_q[BYTE_W-2:0], 1'b0} : {1'b0, sr_q[BYTE_W-1:1]};

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (byte_data),
        .pop       (pop),
        .pop_data  (head),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            sent_q    <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_ne) begin
                        sr_q      <= head;
                        bit_cnt_q <= 3'd7;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (bit_cnt_q == 3'd0) begin
                            sent_q <= sent_q + 16'd1;
                            if (fifo_ne) begin
                                sr_q      <= head;
                                bit_cnt_q <= 3'd7;
                            end else begin
                                sr_q    <= '0;
                                state_q <= IDLE;
                            end
                        end else begin
                            sr_q      <= sr_shift_d;
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_valid  = (state_q == SHIFT);
    assign bit_out    = bit_valid && (MSB_FIRST ? sr_q[BYTE_W-1] : sr_q[0]);
    assign busy       = (state_q == SHIFT) || fifo_ne;
    assign fifo_level = level;
    assign bytes_sent = sent_q;

endmodule
